p2s_serializer: RTL and testbench

- Parallel-to-serial stage that sits directly upstream of the serial sequence detector.
- Accepts DATA_W-bit words over a valid/ready load handshake and shifts them out one bit per clock on dout, which drives the detector's din.
- Back-to-back words stream with no gap, so bit patterns that span word boundaries still reach the detector.
- Provides dout_valid and a per-word frame_done strobe so the bench and the control logic can align detector flags to word positions.

---
 rtl/p2s_serializer_if.sv | 22 ++
 rtl/p2s_serializer.sv | 98 +++++++++
 tb/tb_p2s_serializer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/p2s_serializer_if.sv
// Load handshake and serial output bundle for p2s_serializer.
// master = upstream/consumer side, slave = serializer side.
interface p2s_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              load_valid;
    logic              load_ready;
    logic              dout;
    logic              dout_valid;
    logic              frame_done;

    modport master (
        output data_in, load_valid,
        input  load_ready, dout, dout_valid, frame_done
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, dout, dout_valid, frame_done
    );
endinterface

// File: rtl/p2s_serializer.sv
// Parallel-to-serial: one DATA_W word per valid/ready load, one bit per clock on dout.
// Latency: first bit on dout the cycle after the accepting edge; words stream gap-free.
// Backpressure: load_ready only in IDLE or while the last bit of a word is on dout.
// Optional P2S_LSB_FIRST_EN: shift LSB first instead of MSB first.
module p2s_serializer #(
    parameter int   DATA_W   = 8,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    p2s_serializer_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                dout_q,  dout_d;
    logic                vld_q,   vld_d;
    logic                load_ready;
    logic                frame_done;
    logic                accept;

    assign accept = bus.load_valid && load_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            dout_q  <= IDLE_VAL;
            vld_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        vld_d   = vld_q;

        if (state_q == SHIFT && cnt_q != '0) begin
`ifdef P2S_LSB_FIRST_EN
            dout_d  = shreg_q[0];
            shreg_d = shreg_q >> 1;
`else
            dout_d  = shreg_q[DATA_W-1];
            shreg_d = shreg_q << 1;
`endif
            cnt_d   = cnt_q - CNT_W'(1);
        end else if (accept) begin
            // Reload on the last bit keeps dout_valid high across word boundaries
`ifdef P2S_LSB_FIRST_EN
            dout_d  = bus.data_in[0];
            shreg_d = bus.data_in >> 1;
`else
            dout_d  = bus.data_in[DATA_W-1];
            shreg_d = bus.data_in << 1;
`endif
            cnt_d   = CNT_W'(DATA_W - 1);
            vld_d   = 1'b1;
            state_d = SHIFT;
        end else if (state_q == SHIFT) begin
            dout_d  = IDLE_VAL;
            vld_d   = 1'b0;
            state_d = IDLE;
        end
    end

    // Outputs
    always_comb begin
        load_ready = (state_q == IDLE) || (state_q == SHIFT && cnt_q == '0);
        frame_done = vld_q && (cnt_q == '0);
    end

    assign bus.load_ready = load_ready;
    assign bus.frame_done = frame_done;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = vld_q;
endmodule

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: directed and random loads checked against a bit-queue model.
module tb_p2s_serializer;
    localparam int   DW   = 8;
    localparam logic IDLE = 1'b0;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    bit   exp_q[$];
    logic last_acc;

    p2s_serializer_if #(.DATA_W(DW)) bus ();

    p2s_serializer #(.DATA_W(DW), .IDLE_VAL(IDLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Model: queue holds the bits still to appear on dout, front = current bit.
    task automatic check_outputs(input string tag);
        logic e_vld;
        logic e_dout;
        e_vld  = (exp_q.size() > 0);
        e_dout = e_vld ? exp_q[0] : IDLE;
        check({tag, ".dout"},       bus.dout,       e_dout);
        check({tag, ".dout_valid"}, bus.dout_valid, e_vld);
        check({tag, ".frame_done"}, bus.frame_done, exp_q.size() == 1);
        check({tag, ".load_ready"}, bus.load_ready, exp_q.size() <= 1);
    endtask

    task automatic step(input string tag, input logic lv, input logic [DW-1:0] d);
        logic acc;
        bus.load_valid = lv;
        bus.data_in    = d;
        #1;
        check({tag, ".ready_pre"}, bus.load_ready, exp_q.size() <= 1);
        acc = lv && (exp_q.size() <= 1);
        @(posedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
`ifdef P2S_LSB_FIRST_EN
            for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
`else
            for (int i = DW - 1; i >= 0; i--) exp_q.push_back(d[i]);
`endif
        end
        last_acc = acc;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 'x);
    endtask

    // Upstream holds a word until it is accepted, bounded by a cycle budget.
    task automatic send(input string tag, input logic [DW-1:0] d);
        int budget;
        budget   = 4 * DW;
        last_acc = 1'b0;
        while (!last_acc && budget > 0) begin
            step(tag, 1'b1, d);
            budget--;
        end
        vectors++;
        if (!last_acc) begin
            miscompares++;
            $error("FAIL %s.accept_timeout observed=0 expected=1", tag);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        last_acc       = 1'b0;
        rst_n          = 1'b0;
        bus.load_valid = 1'b0;
        bus.data_in    = '0;
        #2;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle("idle_x", 3);

        // Single word, then drain
        step("single", 1'b1, 8'hB4);
        idle("single", 9);

        // Back-to-back
        send("b2b_ff", 8'hFF);
        send("b2b_00", 8'h00);
        idle("b2b", 9);

        // Hold-off: data_in changes every cycle while load_valid stays high
        for (int i = 0; i < 3 * DW; i++) step("holdoff", 1'b1, DW'($urandom));
        idle("holdoff", DW + 1);

        // Reset mid-word, checked before the next edge
        step("rst_mid", 1'b1, 8'hA5);
        idle("rst_mid", 2);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_outputs("rst_async");
        @(negedge clk);
        check_outputs("rst_hold");
        rst_n = 1'b1;
        step("post_rst", 1'b1, 8'h3C);
        idle("post_rst", 9);

        // Boundary-spanning pattern
        send("chain_56", 8'h56);
        send("chain_b0", 8'hB0);
        idle("chain", 9);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) != 0) step("rand", 1'b1, DW'($urandom));
            else                        step("rand", 1'b0, 'x);
        end
        idle("rand_drain", DW + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog observed=timeout expected=finish");
    end
endmodule
